mult_control: RTL and testbench

//   Control FSM for the 16x16 shift-add multiplier.

---
 rtl/mult_control.sv | 82 ++++++++
 tb/tb_mult_control.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_control.sv
// Shift-add multiplier sequencer: Load, then per multiplier bit an optional Ad and a Sh, then a one-cycle Done.
// Latency 2*N_BITS+k+2 cycles from Start to Done (k = multiplier ones); Start is only sampled in IDLE, never queued.
module mult_control #(
  parameter int N_BITS = 16,
  parameter int CNT_W  = $clog2(N_BITS)
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Start,
  input  logic M,
  output logic Load,
  output logic Ad,
  output logic Sh,
  output logic Busy,
  output logic Done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TEST  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Counts completed shifts; the exit is taken at the last value so it never wraps.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt <= '0;
    end else if (state == LOAD) begin
      cnt <= '0;
    end else if (state == SHIFT && cnt != CNT_LAST) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (Start) next_state = LOAD;
      LOAD:    next_state = TEST;
      TEST:    next_state = M ? ADD : SHIFT;
      ADD:     next_state = SHIFT;
      SHIFT:   next_state = (cnt == CNT_LAST) ? DONE : TEST;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Moore decode keeps the strobes mutually exclusive and glitch-free of M.
  always_comb begin
    Load = 1'b0;
    Ad   = 1'b0;
    Sh   = 1'b0;
    Busy = 1'b0;
    Done = 1'b0;
    case (state)
      LOAD:  begin Load = 1'b1; Busy = 1'b1; end
      TEST:  Busy = 1'b1;
      ADD:   begin Ad = 1'b1; Busy = 1'b1; end
      SHIFT: begin Sh = 1'b1; Busy = 1'b1; end
      DONE:  Done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_control.sv
module tb_mult_control;

  logic Clk = 1'b0;
  logic Rst;
  logic Start;
  logic M;
  logic Load, Ad, Sh, Busy, Done;

  always #5 Clk = ~Clk;

  mult_control #(.N_BITS(16), .CNT_W(4)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .M(M),
    .Load(Load), .Ad(Ad), .Sh(Sh), .Busy(Busy), .Done(Done)
  );

  // Accumulator + adder model driven by the DUT strobes.
  logic [32:0] acc;
  logic [15:0] mplier;
  logic [15:0] mcand;

  assign M = acc[0];

  always @(posedge Clk) begin
    if (Load)    acc <= {17'b0, mplier};
    else if (Ad) acc[32:16] <= 17'(acc[31:16]) + 17'(mcand);
    else if (Sh) acc <= acc >> 1;
  end

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  int r_loads, r_shs, r_busy, r_extra_done;
  int r_ad_mask;
  int r_ads[3];
  int r_done_cyc[3];
  int r_load_cyc[3];

  task automatic run_ops(input int nops,
                         input logic [15:0] mp0, input logic [15:0] mc0,
                         input logic [15:0] mp1, input logic [15:0] mc1,
                         input logic [15:0] mp2, input logic [15:0] mc2,
                         input bit hold, input bit pulses);
    logic [15:0] mps[3];
    logic [15:0] mcs[3];
    logic [31:0] e;
    int op, cyc, iter;
    mps[0] = mp0; mps[1] = mp1; mps[2] = mp2;
    mcs[0] = mc0; mcs[1] = mc1; mcs[2] = mc2;
    r_loads = 0; r_shs = 0; r_busy = 0; r_ad_mask = 0; r_extra_done = 0;
    for (int i = 0; i < 3; i++) begin
      r_ads[i] = 0; r_done_cyc[i] = -1; r_load_cyc[i] = -1;
    end
    op = 0; cyc = 0; iter = 0;
    mplier = mps[0];
    mcand  = mcs[0];
    exp_q.push_back(32'(mps[0]) * 32'(mcs[0]));
    Start = 1'b1;
    while (op < nops && cyc < 200 * nops) begin
      @(negedge Clk);
      cyc++;
      if (!hold) Start = pulses && (cyc == 5 || cyc == 20);
      total++;
      if (!$onehot0({Load, Ad, Sh})) begin
        bad++;
        $display("FAIL strobe_onehot cyc=%0d got LoadAdSh=%b want at most one high", cyc, {Load, Ad, Sh});
      end
      if (Load) begin r_loads++; r_load_cyc[op] = cyc; iter = 0; end
      if (Ad) begin
        r_ads[op]++;
        if (op == 0) r_ad_mask |= (1 << iter);
      end
      if (Sh) begin r_shs++; iter++; end
      if (Busy) r_busy++;
      if (Done) begin
        r_done_cyc[op] = cyc;
        e = exp_q.pop_front();
        total++;
        if (acc[31:0] !== e) begin
          bad++;
          $display("FAIL product op=%0d got=%h want=%h", op, acc[31:0], e);
        end
        op++;
        if (op < nops) begin
          mplier = mps[op];
          mcand  = mcs[op];
          exp_q.push_back(32'(mps[op]) * 32'(mcs[op]));
        end else begin
          Start = 1'b0;
        end
      end
    end
    Start = 1'b0;
    if (op < nops) begin
      total++; bad++;
      $display("FAIL done_timeout got=%0d dones want=%0d", op, nops);
      exp_q.delete();
    end
    repeat (4) begin
      @(negedge Clk);
      if (Load) r_loads++;
      if (Done) r_extra_done++;
    end
  endtask

  task automatic test_reset;
    Rst = 1'b0; Start = 1'b0; mplier = '0; mcand = '0;
    #12;
    total++;
    if ({Load, Ad, Sh, Busy, Done} !== 5'b0) begin
      bad++; $display("FAIL reset_outputs got=%b want=00000", {Load, Ad, Sh, Busy, Done});
    end
    @(negedge Clk); Rst = 1'b1;
    @(negedge Clk);
    total++;
    if ({Load, Ad, Sh, Busy, Done} !== 5'b0) begin
      bad++; $display("FAIL idle_outputs got=%b want=00000", {Load, Ad, Sh, Busy, Done});
    end
  endtask

  task automatic test_reset_mid_add;
    int n;
    mplier = 16'h0001; mcand = 16'h0007;
    Start = 1'b1;
    n = 0;
    do begin
      @(negedge Clk);
      Start = 1'b0;
      n++;
    end while (!Ad && n < 10);
    total++;
    if (!Ad) begin
      bad++; $display("FAIL reach_add got Ad=%b want 1", Ad);
    end
    #2 Rst = 1'b0;
    #1;
    total++;
    if ({Load, Ad, Sh, Busy, Done} !== 5'b0) begin
      bad++; $display("FAIL async_reset got=%b want=00000", {Load, Ad, Sh, Busy, Done});
    end
    @(negedge Clk);
    Rst = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      total++;
      if ({Busy, Done} !== 2'b0) begin
        bad++; $display("FAIL abandoned_op got BusyDone=%b want=00", {Busy, Done});
      end
    end
    run_ops(1, 16'h8001, 16'h0009, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    total++;
    if (r_done_cyc[0] !== 36) begin
      bad++; $display("FAIL post_reset_done got=%0d want=36", r_done_cyc[0]);
    end
  endtask

  task automatic test_zero;
    run_ops(1, 16'h0000, 16'h1234, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    total++;
    if (r_loads !== 1 || r_ads[0] !== 0 || r_shs !== 16) begin
      bad++; $display("FAIL zero_strobes got load=%0d ad=%0d sh=%0d want 1/0/16", r_loads, r_ads[0], r_shs);
    end
    total++;
    if (r_done_cyc[0] !== 34 || r_busy !== 33) begin
      bad++; $display("FAIL zero_timing got done=%0d busy=%0d want 34/33", r_done_cyc[0], r_busy);
    end
  endtask

  task automatic test_all_ones;
    run_ops(1, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    total++;
    if (r_ads[0] !== 16 || r_shs !== 16) begin
      bad++; $display("FAIL ones_strobes got ad=%0d sh=%0d want 16/16", r_ads[0], r_shs);
    end
    total++;
    if (r_done_cyc[0] !== 50 || r_busy !== 49) begin
      bad++; $display("FAIL ones_timing got done=%0d busy=%0d want 50/49", r_done_cyc[0], r_busy);
    end
  endtask

  task automatic test_five;
    run_ops(1, 16'h0005, 16'h0003, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    total++;
    if (r_ad_mask !== 32'h5 || r_ads[0] !== 2) begin
      bad++; $display("FAIL five_add_iters got mask=%h n=%0d want 5/2", r_ad_mask, r_ads[0]);
    end
    total++;
    if (r_done_cyc[0] !== 36) begin
      bad++; $display("FAIL five_done got=%0d want=36", r_done_cyc[0]);
    end
  endtask

  task automatic test_start_ignored;
    run_ops(1, 16'h00F0, 16'h0011, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    total++;
    if (r_loads !== 1 || r_extra_done !== 0) begin
      bad++; $display("FAIL busy_start_loads got load=%0d extra_done=%0d want 1/0", r_loads, r_extra_done);
    end
    total++;
    if (r_done_cyc[0] !== 38) begin
      bad++; $display("FAIL busy_start_done got=%0d want=38", r_done_cyc[0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] mp[3];
    int exp_done;
    mp[0] = 16'h0003; mp[1] = 16'h8000; mp[2] = 16'hFFFF;
    run_ops(3, mp[0], 16'h0101, mp[1], 16'h0002, mp[2], 16'h0001, 1'b1, 1'b0);
    total++;
    if (r_load_cyc[0] !== 1 || r_loads !== 3) begin
      bad++; $display("FAIL b2b_loads got first=%0d n=%0d want 1/3", r_load_cyc[0], r_loads);
    end
    exp_done = 34 + $countones(mp[0]);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        total++;
        if (r_load_cyc[i] !== r_done_cyc[i-1] + 2) begin
          bad++; $display("FAIL b2b_gap op=%0d got load=%0d want=%0d", i, r_load_cyc[i], r_done_cyc[i-1] + 2);
        end
        exp_done = exp_done + 1 + 34 + $countones(mp[i]);
      end
      total++;
      if (r_done_cyc[i] !== exp_done) begin
        bad++; $display("FAIL b2b_done op=%0d got=%0d want=%0d", i, r_done_cyc[i], exp_done);
      end
    end
  endtask

  initial begin
    test_reset;
    test_reset_mid_add;
    test_zero;
    test_all_ones;
    test_five;
    test_start_ignored;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
